// File: rtl/corner_stream_packer.sv
// Buffers corner coordinates from the NMS stage in a FIFO and emits them on a
// valid/ready stream, closing every frame with an {dropped, accepted} trailer.
module corner_stream_packer #(
  parameter int FIFO_DEPTH  = 64,
  parameter int MAX_CORNERS = 500,
  parameter int COORD_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     iscorner,
  input  logic [COORD_WIDTH-1:0]   x_coord,
  input  logic [COORD_WIDTH-1:0]   y_coord,
  input  logic                     frame_end,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*COORD_WIDTH-1:0] out_data,
  output logic                     out_last,
  output logic                     overflow
);

  localparam int DW = 2 * COORD_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_RSV  = CW'(FIFO_DEPTH - 1);
  localparam logic [9:0]    MAX_ACC    = 10'(MAX_CORNERS);

  typedef enum logic {COLLECT, TRAILER} state_t;

  state_t        state_q, state_d;
  logic [DW:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic [9:0]    accepted_q, accepted_d;
  logic [9:0]    dropped_q, dropped_d;
  logic [9:0]    pending_q, pending_d;
  logic          overflow_q, overflow_d;
  logic          cornerIn, frameEv, push, pop;
  logic [DW:0]   pushWord;

  function automatic logic [9:0] satInc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign cornerIn  = ce & iscorner;
  assign frameEv   = ce & frame_end;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? mem_q[rdPtr_q][DW-1:0] : '0;
  assign out_last  = out_valid & mem_q[rdPtr_q][DW];
  assign overflow  = overflow_q;

  // Corners are judged against occupancy before this cycle's pop; one slot is
  // always kept free so the trailer can never be blocked by corners.
  // Drops seen while a trailer waits for space belong to the next frame.
  always_comb begin
    state_d    = state_q;
    accepted_d = accepted_q;
    dropped_d  = dropped_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    pushWord   = '0;
    case (state_q)
      COLLECT: begin
        if (cornerIn) begin
          if ((accepted_q < MAX_ACC) && (count_q < DEPTH_RSV)) begin
            push       = 1'b1;
            pushWord   = {1'b0, y_coord, x_coord};
            accepted_d = accepted_q + 10'd1;
          end else begin
            dropped_d  = satInc(dropped_q);
            overflow_d = 1'b1;
          end
        end
        if (frameEv) state_d = TRAILER;
      end
      TRAILER: begin
        if (cornerIn) overflow_d = 1'b1;
        if (count_q < DEPTH_FULL) begin
          push       = 1'b1;
          pushWord   = {1'b1, DW'({dropped_q, accepted_q})};
          accepted_d = '0;
          dropped_d  = cornerIn ? satInc(pending_q) : pending_q;
          pending_d  = '0;
          state_d    = COLLECT;
        end else if (cornerIn) begin
          pending_d = satInc(pending_q);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      accepted_q <= '0;
      dropped_q  <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_q + AW'(push);
      rdPtr_q    <= rdPtr_q + AW'(pop);
      count_q    <= count_q + CW'(push) - CW'(pop);
      accepted_q <= accepted_d;
      dropped_q  <= dropped_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wrPtr_q] <= pushWord;
  end

endmodule

// File: doc/corner_stream_packer.md
Name: corner_stream_packer

Overview:
- Sits directly downstream of the FAST+NMS corner detector.
- Captures every ce-qualified iscorner pulse with its x/y coordinate and buffers it in a FIFO.
- Enforces a per-frame corner budget and emits corners on a valid/ready stream.
- Each frame is closed by a trailer word carrying the accepted and dropped counts, so the descriptor/matching stage or DMA can consume corners without back-pressuring the pixel pipeline.

Parameters:
- FIFO_DEPTH, 64, FIFO entries; power of two, minimum 4.
- MAX_CORNERS, 500, maximum corners accepted per frame; range 1..1023.
- COORD_WIDTH, 10, width of x_coord/y_coord.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- ce  in  1  clock enable of the pixel pipeline; qualifies iscorner and frame_end only.
- iscorner  in  1  corner strobe from NMS.
- x_coord  in  COORD_WIDTH  corner column.
- y_coord  in  COORD_WIDTH  corner row.
- frame_end  in  1  one-cycle pulse after the last pixel of a frame has left NMS.
- out_valid  out  1  out_data/out_last hold a word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  2*COORD_WIDTH  corner word {y,x}, or trailer word {dropped[9:0], accepted[9:0]}.
- out_last  out  1  1 marks the trailer word.
- overflow  out  1  sticky: at least one corner was dropped since reset.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO is emptied; state goes to COLLECT; accepted and dropped counters go to 0.
  - Outputs: out_valid=0, out_data=0, out_last=0, overflow=0.
  - Reset mid-frame or mid-handshake discards all buffered words, including an offered but unaccepted word.
- Input event: corner_in = ce & iscorner. The frame event is fe = ce & frame_end. Inputs are ignored when ce=0.
- The output side, FIFO pop and out_ready handling are independent of ce.
- FIFO:
  - Single write port, synchronous.
  - Entries are {last, data}.
  - Pop occurs on out_valid && out_ready.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - out_data/out_last are stable while out_valid=1 and out_ready=0.
- Latency: a push into an empty FIFO at edge N gives out_valid=1 after edge N, i.e. one cycle.
- State COLLECT:
  - corner_in is accepted if accepted < MAX_CORNERS and occupancy (before this cycle's pop) < FIFO_DEPTH-1.
    - Accept: push {0,{y,x}}, accepted += 1.
    - Reject: dropped += 1 (saturates at 1023), overflow <= 1.
  - One slot is always held back so the trailer fits.
  - fe goes to TRAILER. A corner_in in the same cycle as fe belongs to the ending frame and is handled by the rules above first.
- State TRAILER:
  - If occupancy < FIFO_DEPTH: push {1,{dropped,accepted}} (counts including any same-cycle fe corner), clear both counters to 0, return to COLLECT.
  - Otherwise stay in TRAILER.
  - corner_in while in TRAILER is dropped, counted in the new frame (dropped starts at 1 after the clear), and sets overflow.
  - fe while in TRAILER is ignored.
- Counter widths: accepted and dropped are 10 bits each. accepted never exceeds MAX_CORNERS; dropped saturates at 1023.
- Ordering: words leave in arrival order, and a trailer always follows every corner of its frame.
- Empty frame: fe with no corners still produces trailer {0,0} with out_last=1.

Test Plan:
- Reset, then 3 corners (x,y) = (5,7), (100,20), (639,479) with ce=1 and out_ready=1, then fe -> out_data 0x01C05, 0x05064, 0x77E7F with out_last=0, then trailer 0x00003 with out_last=1; each word is valid one cycle after its input.
- out_ready=0, FIFO_DEPTH=4, 5 corners, then fe -> 3 corners accepted, 2 dropped, overflow=1; release ready -> 3 corner words, then trailer {dropped=2, accepted=3} = 0x00803.
- MAX_CORNERS=2, FIFO_DEPTH=64, 4 corners, fe -> 2 corner words, trailer 0x00802; second frame of 1 corner -> trailer 0x00001 (counters cleared between frames).
- Corner (8,9) and fe in the same ce cycle -> corner word 0x02408, then trailer accepted=1; a corner in the following cycle (TRAILER state, FIFO not full) is dropped and the next frame's trailer reports dropped=1.
- ce=0 with iscorner=1 and frame_end=1 for 10 cycles -> no pushes, no state change; out_valid stays 0 from reset.
- Assert rst while out_valid=1, out_ready=0 and a frame is half collected -> next cycle out_valid=0 and overflow=0; a following 1-corner frame yields trailer 0x00001.
